// File: rtl/scaler_vline_stepper.sv
// Vertical read-side sequencer: steps a fixed-point phase once per output line and emits input line pair + blend weight.
// Optional grid centering for downscale is enabled by defining SCALER_VSTEP_CENTER_EN.
module scaler_vline_stepper #(
  parameter int WEIGHT_W = 8
) (
  input  logic                SYS_CLK,
  input  logic                SYS_RST,
  input  logic                cfg_valid_i,
  input  logic [8:0]          vpos_1st_rdline_i,
  input  logic [8:0]          vlines_in_needed_i,
  input  logic [10:0]         vlines_out_i,
  input  logic [17:0]         v_interp_factor_i,
  input  logic                frame_start_i,
  input  logic                line_req_i,
  output logic                line_rdy_o,
  output logic                line_valid_o,
  output logic [8:0]          rdline_a_o,
  output logic [8:0]          rdline_b_o,
  output logic [WEIGHT_W-1:0] weight_o,
  output logic                last_line_o,
  output logic                frame_done_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_MUL, S_LOAD_PH, S_FRAME_WAIT, S_RUN, S_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [8:0]          r_vpos, r_nin;
  logic [10:0]         r_nout, r_k;
  logic [17:0]         r_fac;
  logic [26:0]         r_step, r_phase0, r_acc;
  logic                r_s1_vld, r_s1_last;
  logic [9:0]          r_s1_sum;
  logic [WEIGHT_W-1:0] r_s1_w;
  logic                r_line_vld, r_last;
  logic [8:0]          r_rdline_a, r_rdline_b;
  logic [WEIGHT_W-1:0] r_weight;

  logic        w_cfg_bad, w_fs_take, w_abort, w_accept, w_s1_done_last;
  logic [26:0] w_phase0;
  logic [9:0]  w_b_raw, w_b_lim;

  assign w_cfg_bad = (vlines_out_i == 11'd0) || (vlines_in_needed_i == 9'd0);
  // A config in the same cycle overrides the frame start.
  assign w_fs_take = frame_start_i && !cfg_valid_i &&
                     (r_state == S_FRAME_WAIT || r_state == S_RUN || r_state == S_DONE);
  assign w_abort        = cfg_valid_i || w_fs_take;
  assign w_accept       = line_req_i && line_rdy_o && !w_abort;
  assign w_s1_done_last = r_s1_vld && r_s1_last && !w_abort;

`ifdef SCALER_VSTEP_CENTER_EN
  assign w_phase0 = (r_step > 27'd131072) ? ((r_step - 27'd131072) >> 1) : 27'd0;
`else
  assign w_phase0 = 27'd0;
`endif

  assign w_b_raw = r_s1_sum + 10'd1;
  assign w_b_lim = {1'b0, r_vpos} + {1'b0, r_nin} - 10'd1;

  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    line_rdy_o   = 1'b0;
    frame_done_o = 1'b0;
    if (cfg_valid_i) begin
      w_state_nxt = w_cfg_bad ? S_IDLE : S_LOAD_MUL;
    end else begin
      case (r_state)
        S_IDLE:       w_state_nxt = S_IDLE;
        S_LOAD_MUL:   w_state_nxt = S_LOAD_PH;
        S_LOAD_PH:    w_state_nxt = S_FRAME_WAIT;
        S_FRAME_WAIT: if (w_fs_take) w_state_nxt = S_RUN;
        S_RUN: begin
          if (w_fs_take)           w_state_nxt = S_RUN;
          else if (w_s1_done_last) w_state_nxt = S_DONE;
        end
        S_DONE:       if (w_fs_take) w_state_nxt = S_RUN;
        default:      w_state_nxt = S_IDLE;
      endcase
    end
    line_rdy_o   = (r_state == S_RUN) && !r_s1_vld;
    frame_done_o = (r_state == S_DONE);
  end

  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      r_vpos     <= '0;
      r_nin      <= '0;
      r_nout     <= '0;
      r_fac      <= '0;
      r_step     <= '0;
      r_phase0   <= '0;
      r_acc      <= '0;
      r_k        <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_w     <= '0;
      r_line_vld <= 1'b0;
      r_last     <= 1'b0;
      r_rdline_a <= '0;
      r_rdline_b <= '0;
      r_weight   <= '0;
    end else begin
      if (cfg_valid_i) begin
        r_vpos <= vpos_1st_rdline_i;
        r_nin  <= vlines_in_needed_i;
        r_nout <= vlines_out_i;
        r_fac  <= v_interp_factor_i;
      end
      if (r_state == S_LOAD_MUL) r_step   <= 27'(r_nin) * 27'(r_fac);
      if (r_state == S_LOAD_PH)  r_phase0 <= w_phase0;

      if (w_fs_take) begin
        r_k   <= '0;
        r_acc <= r_phase0;
      end else if (w_accept) begin
        r_k   <= r_k + 11'd1;
        r_acc <= r_acc + r_step;
      end

      // Add stage: base line index and weight of the accepted line.
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_sum  <= {1'b0, r_vpos} + {1'b0, r_acc[25:17]};
        r_s1_w    <= r_acc[16 -: WEIGHT_W];
        r_s1_last <= (r_k == r_nout - 11'd1);
      end

      // Clamp stage: line b never passes the last covered input line.
      r_line_vld <= r_s1_vld && !w_abort;
      r_last     <= w_s1_done_last;
      if (r_s1_vld) begin
        r_rdline_a <= r_s1_sum[8:0];
        r_rdline_b <= (w_b_raw > w_b_lim) ? w_b_lim[8:0] : w_b_raw[8:0];
        r_weight   <= r_s1_w;
      end
    end
  end

  assign line_valid_o = r_line_vld;
  assign rdline_a_o   = r_rdline_a;
  assign rdline_b_o   = r_rdline_b;
  assign weight_o     = r_weight;
  assign last_line_o  = r_last;

endmodule
